// File: rtl/pic_host_bus_master.sv
// Host-side bus master for an 8259-style PIC: sends the ICW/OCW1 init burst, EOI writes,
// and runs the two-pulse INTA acknowledge, capturing the vector on the second pulse.
module pic_host_bus_master #(
  parameter int PULSE_W = 2,
  parameter int GAP     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_start_i,
  input  logic [7:0] cfg_icw1_i,
  input  logic [7:0] cfg_icw2_i,
  input  logic [7:0] cfg_icw3_i,
  input  logic [7:0] cfg_icw4_i,
  input  logic [7:0] cfg_ocw1_i,
  output logic       cfg_busy_o,
  output logic       cfg_done_o,
  output logic       configured_o,
  input  logic       eoi_req_i,
  input  logic [7:0] eoi_cmd_i,
  input  logic       ack_en_i,
  input  logic       int_in_i,
  output logic       cs_n_o,
  output logic       wr_n_o,
  output logic       rd_n_o,
  output logic       inta_n_o,
  output logic       a0_o,
  output logic [7:0] d_out_o,
  output logic       d_oe_o,
  input  logic [7:0] d_in_i,
  output logic [7:0] vec_o,
  output logic       vec_valid_o,
  output logic       busy_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_SETUP  = 3'd1;
  localparam logic [2:0] W_STROBE = 3'd2;
  localparam logic [2:0] W_HOLD   = 3'd3;
  localparam logic [2:0] A_P1     = 3'd4;
  localparam logic [2:0] A_GAP    = 3'd5;
  localparam logic [2:0] A_P2     = 3'd6;
  localparam logic [2:0] A_DONE   = 3'd7;

  localparam logic [3:0] PW_M1  = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

  // Sequence pointer values: 0=ICW1 1=ICW2 2=ICW3 3=ICW4 4=OCW1, anything above is "done".
  localparam logic [2:0] SEQ_LAST = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] seq_q, seq_d;
  logic [7:0] icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d;
  logic [7:0] icw4_q, icw4_d, ocw1_q, ocw1_d;
  logic       cfg_busy_q, cfg_busy_d;
  logic       cfg_done_q, cfg_done_d;
  logic       configured_q, configured_d;
  logic       eoi_pend_q, eoi_pend_d;
  logic [7:0] eoi_byte_q, eoi_byte_d;
  logic       a0_q, a0_d;
  logic [7:0] data_q, data_d;
  logic [7:0] vec_q, vec_d;
  logic [1:0] sync_q;

  logic       int_s;
  logic       eoi_take;
  logic       eoi_pend_eff;
  logic [7:0] eoi_byte_eff;
  logic [2:0] seq_nxt;

  assign int_s = sync_q[1];

  // Skips ICW3 in single mode (icw1[1]) and ICW4 when IC4 (icw1[0]) is clear.
  function automatic logic [2:0] next_seq(input logic [2:0] cur, input logic [7:0] icw1);
    logic [2:0] n;
    n = cur + 3'd1;
    if (n == 3'd2 && icw1[1])  n = 3'd3;
    if (n == 3'd3 && !icw1[0]) n = 3'd4;
    return n;
  endfunction

  function automatic logic [7:0] seq_byte(input logic [2:0] s, input logic [7:0] b2,
                                          input logic [7:0] b3, input logic [7:0] b4,
                                          input logic [7:0] o1);
    case (s)
      3'd1:    return b2;
      3'd2:    return b3;
      3'd3:    return b4;
      default: return o1;
    endcase
  endfunction

  // A same-cycle eoi_req counts as pending so it can win arbitration immediately.
  assign eoi_take     = eoi_req_i & configured_q;
  assign eoi_pend_eff = eoi_pend_q | eoi_take;
  assign eoi_byte_eff = eoi_take ? eoi_cmd_i : eoi_byte_q;
  assign seq_nxt      = next_seq(seq_q, icw1_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    seq_d        = seq_q;
    icw1_d       = icw1_q;
    icw2_d       = icw2_q;
    icw3_d       = icw3_q;
    icw4_d       = icw4_q;
    ocw1_d       = ocw1_q;
    cfg_busy_d   = cfg_busy_q;
    cfg_done_d   = 1'b0;
    configured_d = configured_q;
    eoi_pend_d   = eoi_pend_q;
    eoi_byte_d   = eoi_byte_q;
    a0_d         = a0_q;
    data_d       = data_q;
    vec_d        = vec_q;

    if (eoi_take) begin
      eoi_pend_d = 1'b1;
      eoi_byte_d = eoi_cmd_i;
    end

    case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          state_d      = W_SETUP;
          seq_d        = 3'd0;
          cfg_busy_d   = 1'b1;
          configured_d = 1'b0;
          eoi_pend_d   = 1'b0;
          icw1_d       = cfg_icw1_i;
          icw2_d       = cfg_icw2_i;
          icw3_d       = cfg_icw3_i;
          icw4_d       = cfg_icw4_i;
          ocw1_d       = cfg_ocw1_i;
          a0_d         = 1'b0;
          data_d       = cfg_icw1_i;
        end else if (eoi_pend_eff) begin
          state_d    = W_SETUP;
          eoi_pend_d = 1'b0;
          a0_d       = 1'b0;
          data_d     = eoi_byte_eff;
        end else if (int_s && ack_en_i && configured_q) begin
          state_d = A_P1;
          cnt_d   = PW_M1;
        end
      end
      W_SETUP: begin
        state_d = W_STROBE;
        cnt_d   = PW_M1;
      end
      W_STROBE: begin
        if (cnt_q == 4'd0) state_d = W_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      W_HOLD: begin
        if (cfg_busy_q && seq_nxt <= SEQ_LAST) begin
          state_d = W_SETUP;
          seq_d   = seq_nxt;
          a0_d    = 1'b1;
          data_d  = seq_byte(seq_nxt, icw2_q, icw3_q, icw4_q, ocw1_q);
        end else begin
          state_d = IDLE;
          if (cfg_busy_q) begin
            cfg_busy_d   = 1'b0;
            cfg_done_d   = 1'b1;
            configured_d = 1'b1;
          end
        end
      end
      A_P1: begin
        if (cnt_q == 4'd0) begin
          state_d = A_GAP;
          cnt_d   = GAP_M1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      A_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = A_P2;
          cnt_d   = PW_M1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      A_P2: begin
        if (cnt_q == 4'd0) begin
          state_d = A_DONE;
          vec_d   = d_in_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      A_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      seq_q        <= 3'd0;
      icw1_q       <= 8'h00;
      icw2_q       <= 8'h00;
      icw3_q       <= 8'h00;
      icw4_q       <= 8'h00;
      ocw1_q       <= 8'h00;
      cfg_busy_q   <= 1'b0;
      cfg_done_q   <= 1'b0;
      configured_q <= 1'b0;
      eoi_pend_q   <= 1'b0;
      eoi_byte_q   <= 8'h00;
      a0_q         <= 1'b0;
      data_q       <= 8'h00;
      vec_q        <= 8'h00;
      sync_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seq_q        <= seq_d;
      icw1_q       <= icw1_d;
      icw2_q       <= icw2_d;
      icw3_q       <= icw3_d;
      icw4_q       <= icw4_d;
      ocw1_q       <= ocw1_d;
      cfg_busy_q   <= cfg_busy_d;
      cfg_done_q   <= cfg_done_d;
      configured_q <= configured_d;
      eoi_pend_q   <= eoi_pend_d;
      eoi_byte_q   <= eoi_byte_d;
      a0_q         <= a0_d;
      data_q       <= data_d;
      vec_q        <= vec_d;
      sync_q       <= {sync_q[0], int_in_i};
    end
  end

  logic in_write;
  assign in_write = (state_q == W_SETUP) || (state_q == W_STROBE) || (state_q == W_HOLD);

  assign cs_n_o       = ~in_write;
  assign wr_n_o       = ~(state_q == W_STROBE);
  assign rd_n_o       = 1'b1;
  assign inta_n_o     = ~((state_q == A_P1) || (state_q == A_P2));
  assign a0_o         = a0_q;
  assign d_out_o      = data_q;
  assign d_oe_o       = in_write;
  assign vec_o        = vec_q;
  assign vec_valid_o  = (state_q == A_DONE);
  assign busy_o       = (state_q != IDLE);
  assign cfg_busy_o   = cfg_busy_q;
  assign cfg_done_o   = cfg_done_q;
  assign configured_o = configured_q;

endmodule
